// File: rtl/regfile_mp.sv
// Multi-read-port register file with one write port, optional hardwired-zero entry 0
// and a post-reset/on-request clear sweep. Define REGFILE_BYPASS_EN for write-first forwarding.
module regfile_mp #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  int NUM_READ = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_req,
  output logic                      ready,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [NUM_READ-1:0]       rd_en,
  input  logic [NUM_READ*AW-1:0]    rd_addr,
  output logic [NUM_READ*WIDTH-1:0] rd_data
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state;
  logic [AW-1:0]    clr_cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ra [NUM_READ];
  logic [WIDTH-1:0] rd_val [NUM_READ];
  logic             wr_ok;

  // A write is accepted only in READY, in range, not to a hardwired zero, and not alongside a clear.
  assign wr_ok = (state == READY) && wr_en && !clear_req &&
                 (int'(wr_addr) < DEPTH) &&
                 !((ZERO_REG != 0) && (wr_addr == '0));

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      ra[i]     = rd_addr[i*AW +: AW];
      rd_val[i] = '0;
      if ((int'(ra[i]) < DEPTH) && !((ZERO_REG != 0) && (ra[i] == '0)))
        rd_val[i] = mem[ra[i]];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (ra[i] == wr_addr))
        rd_val[i] = wr_data;
`endif
    end
  end

  // NOTE: the storage array has no reset; the clear sweep zeroes it, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[clr_cnt] <= '0;
    else if (wr_ok)
      mem[wr_addr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
      rd_data <= '0;
    end else begin
      case (state)
        CLEAR: begin
          rd_data <= '0;
          if (clr_cnt == AW'(DEPTH - 1)) begin
            state   <= READY;
            ready   <= 1'b1;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        READY: begin
          if (clear_req) begin
            state   <= CLEAR;
            ready   <= 1'b0;
            clr_cnt <= '0;
            rd_data <= '0;
          end else begin
            for (int i = 0; i < NUM_READ; i++)
              if (rd_en[i]) rd_data[i*WIDTH +: WIDTH] <= rd_val[i];
          end
        end
        default: begin
          state   <= CLEAR;
          clr_cnt <= '0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: three instances (ZERO_REG=1, ZERO_REG=0, DEPTH=20)
// driven with shared stimulus and compared against a rule-level reference model.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam int NI = 3;
  localparam int DEPTHS [NI] = '{32, 32, 20};
  localparam bit ZEROS  [NI] = '{1'b1, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        reset_a = 1'b1;
  logic        reset_b = 1'b1;
  logic        clear_req = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [1:0]  rd_en = '0;
  logic [9:0]  rd_addr = '0;
  wire  [63:0] rdo [NI];
  wire         rdy [NI];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: contents, cycles left before ready, expected read data.
  logic [31:0] mref   [NI][32];
  int          busy   [NI];
  logic [31:0] exp_rd [NI][2];

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_READ(2), .ZERO_REG(1)) dut0 (
    .clk(clk), .reset(reset_a), .clear_req(clear_req), .ready(rdy[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdo[0]));

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_READ(2), .ZERO_REG(0)) dut1 (
    .clk(clk), .reset(reset_a), .clear_req(clear_req), .ready(rdy[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdo[1]));

  regfile_mp #(.WIDTH(32), .DEPTH(20), .NUM_READ(2), .ZERO_REG(1)) dut2 (
    .clk(clk), .reset(reset_b), .clear_req(clear_req), .ready(rdy[2]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdo[2]));

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      int d   = DEPTHS[k];
      bit rst = (k == 2) ? reset_b : reset_a;
      if (!rst || (busy[k] == 0 && clear_req)) begin
        busy[k] = d;
        for (int a = 0; a < 32; a++) mref[k][a] = '0;
        for (int p = 0; p < 2; p++) exp_rd[k][p] = '0;
      end else if (busy[k] > 0) begin
        busy[k] = busy[k] - 1;
        for (int p = 0; p < 2; p++) exp_rd[k][p] = '0;
      end else begin
        bit accepted = wr_en && (int'(wr_addr) < d) && !(ZEROS[k] && wr_addr == 0);
        for (int p = 0; p < 2; p++) begin
          if (rd_en[p]) begin
            int a = int'(rd_addr[p*5 +: 5]);
            if (BYPASS && accepted && a == int'(wr_addr)) exp_rd[k][p] = wr_data;
            else if (a < d && !(ZEROS[k] && a == 0))     exp_rd[k][p] = mref[k][a];
            else                                          exp_rd[k][p] = '0;
          end
        end
        if (accepted) mref[k][wr_addr] = wr_data;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear_req = 1'b0;
    wr_en     = 1'b0;
    rd_en     = '0;
  endtask

  task automatic test_reset();
    #1;
    reset_a = 1'b0;
    reset_b = 1'b0;
    idle_inputs();
    #1;
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (rdy[k] !== 1'b0 || rdo[k] !== 64'h0) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: ready=%b rd_data=%h, required ready=0 rd_data=0", k, rdy[k], rdo[k]);
      end
    end
    @(negedge clk);
    repeat (3) tick();
    reset_a = 1'b1;
    reset_b = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      tick();
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (rdy[k] !== (busy[k] == 0)) begin
          n_fail++;
          $display("FAIL reset_ready inst%0d cycle %0d: ready=%b required %b", k, c, rdy[k], busy[k] == 0);
        end
      end
    end
    n_checks++;
    if (rdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after_32: ready=%b required 1", rdy[0]);
    end
    for (int a = 0; a < 32; a++) begin
      rd_en   = 2'b11;
      rd_addr = {5'(31 - a), 5'(a)};
      tick();
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (rdo[k] !== 64'h0) begin
          n_fail++;
          $display("FAIL reset_read_zero inst%0d addr %0d: got %h required 0", k, a, rdo[k]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_basic();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0; rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
    tick();
    rd_en = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (rdo[k] !== {32'hDEADBEEF, 32'hDEADBEEF} || rdo[k] !== {exp_rd[k][1], exp_rd[k][0]}) begin
          n_fail++;
          $display("FAIL basic_rw inst%0d step %0d: got %h required %h", k, c, rdo[k], {2{32'hDEADBEEF}});
        end
      end
      rd_addr = 10'($urandom);
      tick();
    end
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
    tick();
    wr_en = 1'b0; rd_en = 2'b01; rd_addr = '0;
    tick();
    rd_en = '0;
    n_checks++;
    if (rdo[0][31:0] !== 32'h0 || rdo[2][31:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_reg_on: got %h/%h required 00000000", rdo[0][31:0], rdo[2][31:0]);
    end
    n_checks++;
    if (rdo[1][31:0] !== 32'h12345678) begin
      n_fail++;
      $display("FAIL zero_reg_off: got %h required 12345678", rdo[1][31:0]);
    end
  endtask

  task automatic test_raw();
    logic [31:0] want;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1;
    tick();
    wr_data = 32'h2; rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    tick();
    wr_en = 1'b0;
    want = BYPASS ? 32'h2 : 32'h1;
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (rdo[k][31:0] !== want || rdo[k][31:0] !== exp_rd[k][0]) begin
        n_fail++;
        $display("FAIL same_cycle_raw inst%0d: got %h required %h", k, rdo[k][31:0], want);
      end
    end
    tick();
    rd_en = '0;
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (rdo[k][31:0] !== 32'h2) begin
        n_fail++;
        $display("FAIL raw_followup inst%0d: got %h required 00000002", k, rdo[k][31:0]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wr_en   = 1'($urandom);
      wr_addr = 5'($urandom);
      wr_data = $urandom;
      rd_en   = 2'($urandom);
      rd_addr = ($urandom_range(0, 3) == 0) ? {2{wr_addr}} : 10'($urandom);
      tick();
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (rdo[k] !== {exp_rd[k][1], exp_rd[k][0]} || rdy[k] !== 1'b1) begin
          n_fail++;
          $display("FAIL random inst%0d cycle %0d: got %h ready=%b required %h ready=1",
                   k, c, rdo[k], rdy[k], {exp_rd[k][1], exp_rd[k][0]});
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int cycles;
    for (int a = 1; a < 32; a++) begin
      wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'(a * 32'h11);
      tick();
    end
    clear_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAA;
    tick();
    idle_inputs();
    cycles = 0;
    while (rdy[0] !== 1'b1 && cycles < 100) begin
      n_checks++;
      if (rdy[0] !== (busy[0] == 0) || rdo[0] !== 64'h0) begin
        n_fail++;
        $display("FAIL clear_sweep cycle %0d: ready=%b rd_data=%h required ready=0 rd_data=0", cycles, rdy[0], rdo[0]);
      end
      tick();
      cycles++;
    end
    n_checks++;
    if (cycles != 32) begin
      n_fail++;
      $display("FAIL clear_duration: ready low for %0d cycles, required 32", cycles);
    end
    for (int a = 0; a < 32; a++) begin
      rd_en = 2'b11; rd_addr = {5'(a), 5'(a)};
      tick();
      n_checks++;
      if (rdo[0] !== 64'h0 || rdo[1] !== 64'h0) begin
        n_fail++;
        $display("FAIL clear_read addr %0d: got %h/%h required 0", a, rdo[0], rdo[1]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_midsweep_reset();
    int cycles;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    #2;
    reset_b = 1'b0;
    #1;
    n_checks++;
    if (rdy[2] !== 1'b0 || rdo[2] !== 64'h0) begin
      n_fail++;
      $display("FAIL midsweep_async_reset: ready=%b rd_data=%h required 0/0", rdy[2], rdo[2]);
    end
    @(negedge clk);
    repeat (2) tick();
    reset_b = 1'b1;
    cycles = 0;
    while (rdy[2] !== 1'b1 && cycles < 100) begin
      tick();
      cycles++;
    end
    n_checks++;
    if (cycles != 20) begin
      n_fail++;
      $display("FAIL midsweep_restart: ready after %0d cycles, required 20", cycles);
    end
    while (busy[0] > 0 || busy[1] > 0) tick();
    for (int a = 0; a < 20; a++) begin
      wr_en = 1'b1; wr_addr = 5'(a); wr_data = $urandom;
      tick();
    end
    wr_addr = 5'd25; wr_data = 32'h55;
    tick();
    wr_en = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd_en = 2'b11; rd_addr = {5'(a), 5'(25)};
      tick();
      n_checks++;
      if (rdo[2][31:0] !== 32'h0 || rdo[2][63:32] !== exp_rd[2][1]) begin
        n_fail++;
        $display("FAIL out_of_range addr %0d: got %h required %h", a, rdo[2], {exp_rd[2][1], 32'h0});
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      busy[k] = DEPTHS[k];
      exp_rd[k][0] = '0;
      exp_rd[k][1] = '0;
      for (int a = 0; a < 32; a++) mref[k][a] = '0;
    end
    test_reset();
    test_basic();
    test_zero_reg();
    test_raw();
    test_random();
    test_clear();
    test_midsweep_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
